// File: rtl/array_ctrl_pkg.sv
// array_ctrl_pkg: shared widths and grant encoding for the array request controller.
package array_ctrl_pkg;
    localparam int ARR_ADDR_W = 9;
    localparam int ARR_DATA_W = 16;
    typedef enum logic {GRANT_WRITE, GRANT_READ} grant_e;
endpackage

// File: rtl/array_rsp_fifo.sv
// array_rsp_fifo: synchronous response FIFO with occupancy count, head always presented on rdata_o.
module array_rsp_fifo
    import array_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DATA_W = ARR_DATA_W,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CW-1:0]     count_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= inc(wptr_q);
            end
            if (pop_i) rptr_q <= inc(rptr_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    // The upstream credit rule must make these unreachable.
    overflow_chk: assert property (@(posedge clock) disable iff (!reset_n)
        push_i && !pop_i |-> count_q < CW'(DEPTH));
    underflow_chk: assert property (@(posedge clock) disable iff (!reset_n)
        pop_i |-> count_q != '0);
endmodule

// File: rtl/array_req_ctrl.sv
// array_req_ctrl: serialises write/read channels onto a single-port array, round-robin on contention,
// with credit-checked reads so every issued read has a guaranteed response slot.
module array_req_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int ADDR_W = ARR_ADDR_W,
    parameter int DATA_W = ARR_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              arr_en,
    output logic              arr_wmode,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W-1:0] arr_wdata,
    input  logic [DATA_W-1:0] arr_rdata
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    grant_e            last_q, last_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [CW:0]       occ;
    logic              fifo_empty, fifo_push, fifo_pop, pop_any;
    logic              wr_elig, rd_elig, gnt_w, gnt_r;

    array_rsp_fifo #(.DEPTH(RSP_DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (arr_rdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    always_comb begin
        fifo_empty = fifo_count == '0;
        // An empty FIFO lets the in-flight read's data fall through, giving one-cycle latency.
        rsp_valid  = reset_n && (!fifo_empty || inflight_q);
        rsp_data   = !rsp_valid ? '0 : fifo_empty ? arr_rdata : fifo_head;
        pop_any    = rsp_valid && rsp_ready;
        fifo_pop   = pop_any && !fifo_empty;
        fifo_push  = inflight_q && !(fifo_empty && rsp_ready);
        occ        = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop_any);
        wr_elig    = reset_n && wr_valid;
        rd_elig    = reset_n && rd_valid && occ < (CW+1)'(RSP_DEPTH);
        gnt_w      = wr_elig && (!rd_elig || last_q == GRANT_READ);
        gnt_r      = rd_elig && !gnt_w;
        last_d     = (wr_elig && rd_elig) ? (gnt_w ? GRANT_WRITE : GRANT_READ) : last_q;
        inflight_d = gnt_r;
        wr_ready   = gnt_w;
        rd_ready   = gnt_r;
        arr_en     = gnt_w || gnt_r;
        arr_wmode  = gnt_w;
        arr_addr   = gnt_w ? wr_addr : gnt_r ? rd_addr : '0;
        arr_wdata  = gnt_w ? wr_data : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            last_q     <= GRANT_READ;
        end else begin
            inflight_q <= inflight_d;
            last_q     <= last_d;
        end
    end
endmodule
